// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings, default widths and control-field layout for pipeline stages
//
// Contents:
//   state_e          : skid-stage FSM state; the encoding doubles as the occupancy count
//   DATA_W_DEF       : default datapath payload width
//   CTRL_W_DEF       : default control payload width
//   CTRL_W_*         : control width carried across each stage boundary
//   CTRL_*_LSB/_BIT  : bit offsets of the fields packed into in_ctrl
//   pack_ctrl()      : builds a full-width control word from its fields
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 24;

  // Control narrows as fields are consumed further down the pipe.
  localparam int CTRL_W_IFID  = 24;
  localparam int CTRL_W_IDEX  = 24;
  localparam int CTRL_W_EXMEM = 16;
  localparam int CTRL_W_MEMWB = 8;

  localparam int CTRL_ALU_OP_LSB = 0;   // 6 bits
  localparam int CTRL_ALU_OP_W   = 6;
  localparam int CTRL_SRC_A_LSB  = 6;   // 2 bits
  localparam int CTRL_SRC_B_LSB  = 8;   // 2 bits
  localparam int CTRL_REG_WE_BIT = 10;
  localparam int CTRL_MEM_WE_BIT = 11;
  localparam int CTRL_MEM_RE_BIT = 12;
  localparam int CTRL_WB_SEL_LSB = 13;  // 2 bits
  localparam int CTRL_RD_LSB     = 15;  // 5 bits
  localparam int CTRL_RD_W       = 5;

  function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
    input logic [CTRL_ALU_OP_W-1:0] alu_op,
    input logic [1:0]               src_a,
    input logic [1:0]               src_b,
    input logic                     reg_we,
    input logic                     mem_we,
    input logic                     mem_re,
    input logic [1:0]               wb_sel,
    input logic [CTRL_RD_W-1:0]     rd
  );
    logic [CTRL_W_DEF-1:0] c;
    c = '0;
    c[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W] = alu_op;
    c[CTRL_SRC_A_LSB  +: 2]             = src_a;
    c[CTRL_SRC_B_LSB  +: 2]             = src_b;
    c[CTRL_REG_WE_BIT]                  = reg_we;
    c[CTRL_MEM_WE_BIT]                  = mem_we;
    c[CTRL_MEM_RE_BIT]                  = mem_re;
    c[CTRL_WB_SEL_LSB +: 2]             = wb_sel;
    c[CTRL_RD_LSB     +: CTRL_RD_W]     = rd;
    return c;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one payload register (data + control) with load enable and control clear
//
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : capture data_i/ctrl_i on the next rising edge
//   clr_i          : force the control word to RST_CTRL; data is kept (wins over load_i)
//   data_i, ctrl_i : payload to capture
//   data_o, ctrl_o : held payload
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]  RST_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clearing only the control word is enough to make a slot harmless
  // downstream, and leaving data untouched keeps out_data stable in bubbles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      ctrl_q <= RST_CTRL;
    end else if (clr_i) begin
      ctrl_q <= RST_CTRL;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffered pipeline register with valid/ready handshake and flush
//
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   in_valid/in_ready       : upstream handshake; in_ready depends only on held state
//   in_data, in_ctrl        : upstream payload
//   flush                   : synchronous kill of every held beat and of any same-cycle input
//   out_valid/out_ready     : downstream handshake
//   out_data, out_ctrl      : downstream payload; out_ctrl is RST_CTRL whenever out_valid=0
//   occupancy               : beats held (0..2), equal to the FSM state encoding
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]  RST_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_e state_q;

  logic              acc;
  logic              deq;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Ready is a pure decode of the registered state, so out_ready never
  // reaches it. Gating with rst_n_i holds it low while reset is applied and
  // lets the first edge after release accept a beat.
  assign in_ready  = rst_n_i && (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;

  assign acc = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  // Entry control. The skid is only filled when main is full and not
  // draining; it always drains into main before main takes new input.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // A same-cycle output transfer already consumed main's beat; clearing
      // both entries drops everything else, including any input beat.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          main_load = acc;
        end
        ST_ONE: begin
          if (acc && !deq) begin
            skid_load = 1'b1;
          end else if (acc && deq) begin
            main_load = 1'b1;
          end else if (deq) begin
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (deq) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) state_q <= ST_ONE;
        ST_ONE: begin
          if (acc && !deq)      state_q <= ST_TWO;
          else if (!acc && deq) state_q <= ST_EMPTY;
        end
        ST_TWO:   if (deq) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  pipe_entry #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_CTRL (RST_CTRL)
  ) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  pipe_entry #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_CTRL (RST_CTRL)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

  // Main's control is cleared whenever the stage empties, so it already
  // reads RST_CTRL in every bubble.
  assign out_data = main_data;
  assign out_ctrl = main_ctrl;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 24;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .RST_CTRL ('0)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t         q[$];        // beats held by the stage, oldest first
  logic [DW-1:0] last_data;   // payload most recently presented at the output
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string ph);
    int n;
    n = q.size();
    chk({ph, " out_valid"}, 32'(out_valid), 32'(n > 0));
    chk({ph, " in_ready"},  32'(in_ready),  32'(n < 2));
    chk({ph, " occupancy"}, 32'(occupancy), 32'(n));
    chk({ph, " out_ctrl"},  32'(out_ctrl),  (n > 0) ? 32'(q[0].c) : 32'd0);
    chk({ph, " out_data"},  out_data,       (n > 0) ? q[0].d : last_data);
  endtask

  task automatic check_reset(input string ph);
    chk({ph, " out_valid"}, 32'(out_valid), 32'd0);
    chk({ph, " in_ready"},  32'(in_ready),  32'd0);
    chk({ph, " occupancy"}, 32'(occupancy), 32'd0);
    chk({ph, " out_ctrl"},  32'(out_ctrl),  32'd0);
    chk({ph, " out_data"},  out_data,       32'd0);
  endtask

  // One clock: drive inputs, advance the model by the handshake rules, then
  // compare at the following falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic fl, input logic ordy, input string ph);
    bit acc;
    bit deq;
    beat_t b;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    deq = ordy && (q.size() > 0);
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) begin
        b.d = d;
        b.c = c;
        q.push_back(b);
      end
    end
    if (q.size() > 0) last_data = q[0].d;
    @(negedge clk_i);
    check_model(ph);
  endtask

  initial begin
    rst_n_i   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    last_data = '0;

    @(negedge clk_i);
    check_reset("por");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Single beat, one cycle latency, then drained.
    cycle(1'b1, 32'h1234_5678, 24'h00_0A05, 1'b0, 1'b1, "single_in");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "single_out");

    // Back-to-back stream.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'hA000_0000 + 32'(i), 24'h000100 + 24'(i), 1'b0, 1'b1, "stream");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "stream_drain");

    // Stall with two beats, then release.
    cycle(1'b1, 32'hAAAA_0001, 24'h0000A1, 1'b0, 1'b0, "stall_a");
    cycle(1'b1, 32'hBBBB_0002, 24'h0000B2, 1'b0, 1'b0, "stall_b");
    cycle(1'b1, 32'hDEAD_0003, 24'h0000C3, 1'b0, 1'b0, "stall_full");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "release_a");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "release_b");

    // Flush in TWO with a beat offered.
    cycle(1'b1, 32'h1111_0001, 24'h000011, 1'b0, 1'b0, "fill1");
    cycle(1'b1, 32'h2222_0002, 24'h000022, 1'b0, 1'b0, "fill2");
    cycle(1'b1, 32'h3333_0003, 24'h000033, 1'b1, 1'b0, "flush_two");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "after_flush");

    // Flush coinciding with an output transfer.
    cycle(1'b1, 32'h4444_0004, 24'h000044, 1'b0, 1'b0, "fill3");
    cycle(1'b1, 32'h5555_0005, 24'h000055, 1'b0, 1'b0, "fill4");
    cycle(1'b1, 32'h6666_0006, 24'h000066, 1'b1, 1'b1, "flush_deq");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "after_flush_deq");

    // Asynchronous reset between edges while holding beats.
    cycle(1'b1, 32'h7777_0007, 24'h000077, 1'b0, 1'b0, "pre_rst1");
    cycle(1'b1, 32'h8888_0008, 24'h000088, 1'b0, 1'b0, "pre_rst2");
    #2 rst_n_i = 1'b0;
    #1 check_reset("async_rst");
    q.delete();
    last_data = '0;
    in_valid  = 1'b1;
    @(negedge clk_i);
    check_reset("rst_held");
    #2 rst_n_i = 1'b1;
    cycle(1'b1, 32'h9999_0009, 24'h000099, 1'b0, 1'b1, "post_rst");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            $urandom(),
            24'($urandom()),
            ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            "random");
    end
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "final_drain1");
    cycle(1'b0, 32'h0, 24'h0, 1'b0, 1'b1, "final_drain2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, 32, width of the datapath payload (operands, immediate, PC) per beat.
REQ-002 Parameter CTRL_W, 24, width of the control payload (ALU op, selects, write enables, dest reg).
REQ-003 Parameter RST_CTRL, all-zero, control value forced on reset, flush and bubble.
REQ-004 Port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 Port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  upstream beat present.
REQ-007 Port in_ready  output  1  stage can accept a beat; registered, no combinational path from out_ready.
REQ-008 Port in_data  input  DATA_W  upstream datapath payload.
REQ-009 Port in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 Port flush  input  1  synchronous kill of all held beats (branch or jump redirect).
REQ-011 Port out_valid  output  1  downstream beat present; replaces the per-stage have_inst flag.
REQ-012 Port out_ready  input  1  downstream accepts the beat.
REQ-013 Port out_data  output  DATA_W  downstream datapath payload.
REQ-014 Port out_ctrl  output  CTRL_W  downstream control payload; equals RST_CTRL whenever out_valid=0.
REQ-015 Port occupancy  output  2  beats held: 0, 1 or 2.

Function
REQ-016 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-017 Storage: main entry drives the outputs; skid entry catches a beat accepted while main is stalled.
REQ-018 FSM states: EMPTY (occ 0), ONE (main full), TWO (main and skid full).
REQ-019 EMPTY: accept -> ONE, beat in main, latency 1 cycle to out_valid.
REQ-020 ONE: accept without output transfer -> TWO; output transfer without accept -> EMPTY; both -> ONE, main gets the new beat.
REQ-021 TWO: output transfer -> ONE, skid beat moves into main on the same edge; in_ready=0 throughout TWO.
REQ-022 in_ready = 1 in EMPTY and ONE, 0 in TWO, 0 during reset.
REQ-023 Order: beats leave in acceptance order; no beat is duplicated or dropped except by flush.
REQ-024 Flush: on the edge with flush=1 go to EMPTY, out_ctrl=RST_CTRL and out_valid=0 from the next cycle.
REQ-025 Flush with a same-cycle input transfer: the input beat is also discarded; flush has priority.
REQ-026 Flush with a same-cycle output transfer: downstream still consumes the current beat; the other entries are discarded.
REQ-027 Bubble: when out_valid=0, out_data holds its last value and out_ctrl=RST_CTRL, so no spurious writes reach the register file or DRAM.
REQ-028 Payloads pass through unmodified, with no width conversion; data and control of a beat always travel together.
REQ-029 occupancy equals the FSM state encoding at all times.

Reset
REQ-030 While rst_n_i=0: state EMPTY, out_valid=0, in_ready=0, occupancy=0, out_ctrl=RST_CTRL, out_data=0, skid entry=0.
REQ-031 Reset takes effect immediately, including mid-transfer; the first accept is possible on the first rising edge after release.

Structure
REQ-032 Shared package pipe_pkg holds the state encodings ST_EMPTY/ST_ONE/ST_TWO, the default DATA_W/CTRL_W, and the control-field bit offsets used to pack in_ctrl.
REQ-033 One sub-module, pipe_entry (a payload register with load enable and a clear to RST_CTRL), is instantiated twice, for main and skid; no other hierarchy.
REQ-034 Each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) is one instance with its own CTRL_W.

Verification
REQ-035 Single beat: in_data=0x1234_5678, in_ctrl=0x00_0A05, out_ready=1 -> out_valid one cycle later with matching payload, occupancy 1 -> 0.
REQ-036 Back-to-back stream of 8 beats, out_ready=1 -> one beat per cycle, in order, in_ready never drops.
REQ-037 Stall: out_ready=0 while two beats A, B are sent -> state TWO, in_ready=0; then out_ready=1 -> A then B on consecutive cycles.
REQ-038 Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the input beat never appears.
REQ-039 Flush with a same-cycle output transfer -> downstream takes the current beat; nothing further is emitted.
REQ-040 rst_n_i asserted mid-stream, between clock edges -> outputs reach their reset values without waiting for an edge; after release the first beat is accepted on the first edge.
